bcd_angle_updown_counter: RTL
=============================

BCD_ANGLE_UPDOWN_COUNTER -- requirements
Module: bcd_angle_updown_counter

Interface
REQ-001 The block SHALL have a parameter NUM_DIGITS, default 4, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have a parameter MAX_VAL, default 359, giving the decimal wrap limit; the count range is 0..MAX_VAL (legal range 1..10^NUM_DIGITS-1).
REQ-003 The block SHALL have a parameter IS_POSITIVE, default 0, which selects the active edge of rot_clk: 1 = rising, 0 = falling.
REQ-004 The block SHALL have port fpga_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port sys_init_ctrl, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port rot_clk, input, 1 bit: rotation step strobe, asynchronous to nothing (fpga_clk domain level signal).
REQ-007 The block SHALL have port rot_en, input, 1 bit: 1 = steps counted, 0 = steps ignored.
REQ-008 The block SHALL have port rot_dir, input, 1 bit: 1 = count up, 0 = count down; sampled on the step cycle.
REQ-009 The block SHALL have port load, input, 1 bit: single-cycle request to preset the count.
REQ-010 The block SHALL have port load_val, input, 4*NUM_DIGITS bits: BCD preset value, with digit 0 in bits [3:0].
REQ-011 The block SHALL have port bcd_val, output, 4*NUM_DIGITS bits: the current count as registered BCD, with digit 0 in bits [3:0].
REQ-012 The block SHALL have port wrap_up, output, 1 bit: one-cycle pulse on an up-wrap from MAX_VAL to 0.
REQ-013 The block SHALL have port wrap_dn, output, 1 bit: one-cycle pulse on a down-wrap from 0 to MAX_VAL.
REQ-014 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-015 The block SHALL keep an edge-history flop of the (optionally synchronised) rot_clk that updates every cycle, including during reset; step = selected edge between history and current sample.
REQ-016 The block SHALL apply the new bcd_val on the same fpga_clk edge that evaluates step=1 with rot_en=1, so the updated value is visible one cycle after the rot_clk transition is first sampled.
REQ-017 The block SHALL update the count on an up step as follows: if bcd_val==MAX_VAL, the next value is 0 and wrap_up=1; otherwise it is a BCD increment, where a digit at 9 becomes 0 and carries into the next digit.
REQ-018 The block SHALL update the count on a down step as follows: if bcd_val==0, the next value is MAX_VAL and wrap_dn=1; otherwise it is a BCD decrement, where a digit at 0 becomes 9 and borrows from the next digit.
REQ-019 The block SHALL apply the following priority per cycle: sys_init_ctrl > load > step; a step coinciding with load is dropped.
REQ-020 The block SHALL accept a load only if every digit of load_val is 0..9 and the value is <=MAX_VAL; the next cycle then shows bcd_val=load_val.
REQ-021 The block SHALL, on a rejected load, leave bcd_val unchanged and assert load_err for exactly one cycle.
REQ-022 The block SHALL ignore edges while rot_en=0 without losing them from edge tracking, i.e. the history still updates, and the block SHALL NOT issue a retroactive step when rot_en later rises.
REQ-023 The block SHALL ensure wrap_up, wrap_dn and load_err are registered, are mutually exclusive, and are 0 in every cycle without the corresponding event.
REQ-024 The block SHALL hold bcd_val within 0..MAX_VAL with every digit in 0..9 at all times.

Reset
REQ-025 The block SHALL, with sys_init_ctrl=1 at a clock edge, set bcd_val=0, wrap_up=0, wrap_dn=0 and load_err=0, regardless of load or step.
REQ-026 The block SHALL not step on the first cycle after reset release unless a genuine edge occurs after release (the history tracks the input during reset).
REQ-027 The block SHALL, on a reset asserted mid-operation, take effect at the next edge with no partial digit update.

Configuration
REQ-028 The block SHALL support macro BCD_ANGLE_CNT_SYNC_EN; when defined, rot_clk passes through a 2-flop synchroniser before the edge history, adding exactly 2 cycles of step latency, and the synchroniser flops are also cleared to the rot_clk idle level (IS_POSITIVE ? 0 : 1) on reset.
REQ-029 The block SHALL, when BCD_ANGLE_CNT_SYNC_EN is undefined, sample rot_clk directly into the edge history with latency per REQ-016.

Verification
REQ-030 The bench SHALL cover this scenario: defaults, reset, rot_en=1, rot_dir=1, 360 falling edges -> bcd_val counts 0000..0359, then 0000 with one wrap_up pulse.
REQ-031 The bench SHALL cover this scenario: bcd_val=0000, rot_dir=0, one falling edge -> bcd_val=0359, wrap_dn=1 for one cycle; next down edge -> 0358.
REQ-032 The bench SHALL cover this scenario: load_val=16'h0199, load=1, then an up step -> 0199 then 0200 (carry across two digits); load_val=16'h0360 or 16'h01A0 -> load_err pulse, value unchanged.
REQ-033 The bench SHALL cover this scenario: load=1 with a simultaneous step edge -> load value only; sys_init_ctrl=1 with simultaneous load -> 0000.
REQ-034 The bench SHALL cover this scenario: rot_en=0 during 5 edges, then rot_en=1 with no edge -> bcd_val unchanged; rot_clk held low across reset release (IS_POSITIVE=0) -> no step.
REQ-035 The bench SHALL cover this scenario: NUM_DIGITS=2, MAX_VAL=99, with and without BCD_ANGLE_CNT_SYNC_EN -> 99->00 wrap_up, with step latency of 1 versus 3 cycles from the rot_clk transition.

Source files
------------

// File: rtl/bcd_angle_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_angle_updown_counter
//
// Purpose:
//   Up/down BCD counter for angle tracking. Each selected edge of rot_clk
//   (rising when IS_POSITIVE=1, falling when IS_POSITIVE=0) is one step, taken
//   only while rot_en is high. The count runs 0..MAX_VAL and wraps in both
//   directions. A preset can be loaded; out-of-range or non-BCD presets are
//   rejected.
//
// Optional feature:
//   BCD_ANGLE_CNT_SYNC_EN - when defined, rot_clk passes through a 2-flop
//   synchroniser before edge detection (two extra cycles of step latency).
//
// Parameters:
//   NUM_DIGITS  - number of BCD digits (1..8)
//   MAX_VAL     - decimal wrap limit (1..10^NUM_DIGITS-1)
//   IS_POSITIVE - active rot_clk edge: 1 = rising, 0 = falling
//
// Ports:
//   fpga_clk       in   system clock, rising edge
//   sys_init_ctrl  in   synchronous active-high reset
//   rot_clk        in   rotation step strobe (level signal)
//   rot_en         in   1 = steps counted
//   rot_dir        in   1 = up, 0 = down
//   load           in   single-cycle preset request
//   load_val       in   BCD preset, digit 0 in [3:0]
//   bcd_val        out  registered BCD count, digit 0 in [3:0]
//   wrap_up        out  pulse on MAX_VAL -> 0
//   wrap_dn        out  pulse on 0 -> MAX_VAL
//   load_err       out  pulse on rejected load
// -----------------------------------------------------------------------------
module bcd_angle_updown_counter #(
    parameter int NUM_DIGITS  = 4,
    parameter int MAX_VAL     = 359,
    parameter bit IS_POSITIVE = 1'b0
) (
    input  logic                    fpga_clk,
    input  logic                    sys_init_ctrl,
    input  logic                    rot_clk,
    input  logic                    rot_en,
    input  logic                    rot_dir,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] bcd_val,
    output logic                    wrap_up,
    output logic                    wrap_dn,
    output logic                    load_err
);

    localparam int W = 4 * NUM_DIGITS;

    // Build the BCD image of an integer at elaboration time.
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD  = to_bcd(MAX_VAL);
    localparam logic         IDLE_LVL = IS_POSITIVE ? 1'b0 : 1'b1;

    // Ripple-carry BCD increment; caller guarantees the input is not MAX.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement; caller guarantees the input is not zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // -------------------------------------------------------------------------
    // rot_clk conditioning and edge detection
    // -------------------------------------------------------------------------
    logic rot_s;

`ifdef BCD_ANGLE_CNT_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    always_comb begin
        sync1_d = rot_clk;
        sync2_d = sync1_q;
    end

    // Cleared to the idle level so that reset never fabricates an edge when
    // rot_clk is idle.
    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign rot_s = sync2_q;
`else
    assign rot_s = rot_clk;
`endif

    logic hist_q;
    logic hist_d;
    logic step;

    always_comb begin
        hist_d = rot_s;
    end

    // History deliberately has no reset: it tracks the input during reset so
    // a level held across reset release is not seen as an edge, and it keeps
    // tracking while rot_en is low so no step is issued retroactively.
    always_ff @(posedge fpga_clk) begin
        hist_q <= hist_d;
    end

    assign step = IS_POSITIVE ? (rot_s & ~hist_q) : (~rot_s & hist_q);

    // -------------------------------------------------------------------------
    // Count update
    // -------------------------------------------------------------------------
    logic [W-1:0] bcd_q;
    logic [W-1:0] bcd_d;
    logic         wrap_up_q;
    logic         wrap_up_d;
    logic         wrap_dn_q;
    logic         wrap_dn_d;
    logic         load_err_q;
    logic         load_err_d;
    logic         load_ok;

    // BCD values compare numerically once every digit is known to be 0..9.
    assign load_ok = digits_ok(load_val) && (load_val <= MAX_BCD);

    always_comb begin
        bcd_d      = bcd_q;
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // A step in the same cycle is dropped, accepted or not.
            if (load_ok) begin
                bcd_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step && rot_en) begin
            if (rot_dir) begin
                if (bcd_q == MAX_BCD) begin
                    bcd_d     = '0;
                    wrap_up_d = 1'b1;
                end else begin
                    bcd_d = bcd_inc(bcd_q);
                end
            end else begin
                if (bcd_q == '0) begin
                    bcd_d     = MAX_BCD;
                    wrap_dn_d = 1'b1;
                end else begin
                    bcd_d = bcd_dec(bcd_q);
                end
            end
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            bcd_q      <= '0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd_val  = bcd_q;
    assign wrap_up  = wrap_up_q;
    assign wrap_dn  = wrap_dn_q;
    assign load_err = load_err_q;

endmodule
